// File: rtl/icache_responder_pkg.sv
// Shared definitions for the instruction-cache responder: FSM encoding and address-field geometry.
package icache_responder_pkg;

    localparam int XLEN           = 32;
    localparam int DEF_INDEX_BITS = 4;
    localparam int DEF_WORD_BITS  = 2;
    localparam int BYTE_OFF_BITS  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_ACK    = 2'd2
    } icache_state_e;

    function automatic int tag_bits(input int index_bits, input int word_bits);
        return XLEN - index_bits - word_bits - BYTE_OFF_BITS;
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the direct-mapped instruction cache.
// One asynchronous read port, one refill-beat write port, one valid/tag set port, clear-all.
module icache_line_store
    import icache_responder_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int WORD_BITS  = DEF_WORD_BITS,
    parameter int TAG_BITS   = tag_bits(DEF_INDEX_BITS, DEF_WORD_BITS)
) (
    input  logic                  clk_i,
    input  logic                  clear_all_i,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    input  logic [WORD_BITS-1:0]  rd_word_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [XLEN-1:0]       rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [WORD_BITS-1:0]  wr_word_i,
    input  logic [XLEN-1:0]       wr_data_i,
    input  logic                  set_en_i,
    input  logic                  set_valid_i,
    input  logic [INDEX_BITS-1:0] set_index_i,
    input  logic [TAG_BITS-1:0]   set_tag_i
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << WORD_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [XLEN-1:0]     data_q [LINES][WORDS];

    // Clear-all wins over a simultaneous set so reset always leaves every line invalid.
    always_ff @(posedge clk_i) begin
        if (clear_all_i) begin
            valid_q <= '0;
        end else if (set_en_i) begin
            valid_q[set_index_i] <= set_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (set_en_i && set_valid_i) begin
            tag_q[set_index_i] <= set_tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[wr_index_i][wr_word_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i][rd_word_i];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, word-by-word line refill on miss,
// one fetch_ready pulse per request, no response in a cycle following a flush.
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int WORD_BITS  = DEF_WORD_BITS
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            rob_clear_up,
    input  logic [XLEN-1:0] pc,
    input  logic            start_fetch,
    output logic            fetch_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_addr,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_data,
    output icache_state_e   dbg_state_o
);

    localparam int OFF_BITS = WORD_BITS + BYTE_OFF_BITS;
    localparam int TAG_LSB  = OFF_BITS + INDEX_BITS;
    localparam int TAG_BITS = XLEN - TAG_LSB;
    localparam logic [WORD_BITS-1:0] LAST_BEAT = '1;

    icache_state_e         state_q, state_d;
    logic [WORD_BITS-1:0]  cnt_q, cnt_d;
    logic [INDEX_BITS-1:0] line_idx_q, line_idx_d;
    logic [TAG_BITS-1:0]   line_tag_q, line_tag_d;
    logic                  mem_req_q, mem_req_d;
    logic [XLEN-1:0]       mem_addr_q, mem_addr_d;
    logic                  fetch_ready_q, fetch_ready_d;
    logic [XLEN-1:0]       inst_q, inst_d;
    logic [XLEN-1:0]       inst_addr_q, inst_addr_d;

    logic [TAG_BITS-1:0]   pc_tag;
    logic [INDEX_BITS-1:0] pc_index;
    logic [WORD_BITS-1:0]  pc_word;

    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [XLEN-1:0]       rd_data;
    logic                  hit;

    logic                  wr_en;
    logic                  set_en;
    logic                  set_valid;
    logic [INDEX_BITS-1:0] set_index;

    assign pc_tag   = pc[XLEN-1:TAG_LSB];
    assign pc_index = pc[TAG_LSB-1:OFF_BITS];
    assign pc_word  = pc[OFF_BITS-1:BYTE_OFF_BITS];
    assign hit      = rd_valid && (rd_tag == pc_tag);

    icache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .WORD_BITS  (WORD_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk_i       (clk_in),
        .clear_all_i (rst_in),
        .rd_index_i  (pc_index),
        .rd_word_i   (pc_word),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_en_i     (wr_en),
        .wr_index_i  (line_idx_q),
        .wr_word_i   (cnt_q),
        .wr_data_i   (mem_data),
        .set_en_i    (set_en),
        .set_valid_i (set_valid),
        .set_index_i (set_index),
        .set_tag_i   (line_tag_q)
    );

    // With rdy_in low every register keeps its value and the arrays see no writes.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        line_idx_d    = line_idx_q;
        line_tag_d    = line_tag_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        fetch_ready_d = fetch_ready_q;
        inst_d        = inst_q;
        inst_addr_d   = inst_addr_q;
        wr_en         = 1'b0;
        set_en        = 1'b0;
        set_valid     = 1'b0;
        set_index     = line_idx_q;

        if (rdy_in) begin
            fetch_ready_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_fetch && !rob_clear_up) begin
                        if (hit) begin
                            fetch_ready_d = 1'b1;
                            inst_d        = rd_data;
                            inst_addr_d   = pc;
                            state_d       = ST_ACK;
                        end else begin
                            // Drop the victim immediately so an abandoned refill never looks valid.
                            set_en     = 1'b1;
                            set_valid  = 1'b0;
                            set_index  = pc_index;
                            line_idx_d = pc_index;
                            line_tag_d = pc_tag;
                            cnt_d      = '0;
                            mem_req_d  = 1'b1;
                            mem_addr_d = {pc[XLEN-1:OFF_BITS], {OFF_BITS{1'b0}}};
                            state_d    = ST_REFILL;
                        end
                    end
                end
                ST_REFILL: begin
                    if (mem_ready) begin
                        wr_en      = 1'b1;
                        cnt_d      = cnt_q + 1'b1;
                        mem_addr_d = mem_addr_q + 32'd4;
                        if (cnt_q == LAST_BEAT) begin
                            mem_req_d = 1'b0;
                            set_en    = 1'b1;
                            set_valid = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
                ST_ACK: begin
                    // start_fetch is still high for this request; ignore it.
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            line_idx_q    <= '0;
            line_tag_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            fetch_ready_q <= 1'b0;
            inst_q        <= '0;
            inst_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            line_idx_q    <= line_idx_d;
            line_tag_q    <= line_tag_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            fetch_ready_q <= fetch_ready_d;
            inst_q        <= inst_d;
            inst_addr_q   <= inst_addr_d;
        end
    end

    assign fetch_ready = fetch_ready_q;
    assign inst        = inst_q;
    assign inst_addr   = inst_addr_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: memory model with random beat gaps, response scoreboard,
// a table of fetches, and hand-written flush / freeze / reset-mid-refill sequences.
module tb_icache_responder;
    import icache_responder_pkg::*;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          rob_clear_up;
    logic [31:0]   pc;
    logic          start_fetch;
    logic          fetch_ready;
    logic [31:0]   inst;
    logic [31:0]   inst_addr;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ready;
    logic [31:0]   mem_data;
    icache_state_e dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] beat_q[$];
    bit          flush_prev = 1'b0;

    typedef struct {
        logic [31:0] addr;
        bit          miss;
    } vec_t;
    vec_t vecs[12];

    icache_responder dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .rob_clear_up (rob_clear_up),
        .pc           (pc),
        .start_fetch  (start_fetch),
        .fetch_ready  (fetch_ready),
        .inst         (inst),
        .inst_addr    (inst_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_data     (mem_data),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: one beat per pulse, random idle gaps, never drives during reset or freeze.
    initial begin
        int gap = 0;
        mem_ready = 1'b0;
        mem_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ready = 1'b0;
            if (mem_req && rdy_in && !rst_in) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    mem_ready = 1'b1;
                    mem_data  = mem_word(mem_addr);
                    if (beat_q.size() == 0) begin
                        check("unexpected_beat_addr", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        check("beat_addr", mem_addr, beat_q.pop_front());
                    end
                    gap = $urandom_range(0, 2);
                end
            end
        end
    end

    always @(posedge clk) flush_prev = rob_clear_up && rdy_in && !rst_in;

    // Response monitor: every pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst_in && fetch_ready) begin
            check("pulse_after_flush", {31'b0, flush_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_addr", inst_addr, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("inst_addr", inst_addr, e[63:32]);
                check("inst", inst, e[31:0]);
            end
        end
    end

    task automatic do_reset();
        rst_in       = 1'b1;
        start_fetch  = 1'b0;
        rob_clear_up = 1'b0;
        rdy_in       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_fetch_ready", {31'b0, fetch_ready}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_addr", inst_addr, 32'd0);
        check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        exp_q.delete();
        beat_q.delete();
        @(posedge clk);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic push_line(input logic [31:0] a);
        for (int i = 0; i < 4; i++) beat_q.push_back({a[31:4], 4'b0} + 32'(4 * i));
    endtask

    task automatic issue(input logic [31:0] a, input bit miss);
        if (miss) push_line(a);
        exp_q.push_back({a, mem_word(a)});
        pc          = a;
        start_fetch = 1'b1;
    endtask

    task automatic wait_pulse(input string name, input bit miss);
        int cyc = 0;
        bit req_seen = 1'b0;
        bit got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (mem_req) req_seen = 1'b1;
            if (fetch_ready) begin
                got = 1'b1;
                break;
            end
            cyc++;
        end
        check({name, "_pulse_seen"}, {31'b0, got}, 32'd1);
        if (got) begin
            check({name, "_mem_req"}, {31'b0, req_seen}, {31'b0, miss});
            if (!miss) check({name, "_hit_latency"}, cyc, 32'd1);
        end
        // The fetcher drops start_fetch one edge late, i.e. through the ACK edge.
        @(posedge clk);
        #1;
        start_fetch = 1'b0;
        tick();
    endtask

    task automatic wait_addr(input string name, input logic [31:0] a);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_addr == a) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_reached"}, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear_up = 1'b0; pc = '0; start_fetch = 1'b0;
        vecs[0]  = '{32'h000, 1'b1};
        vecs[1]  = '{32'h008, 1'b0};
        vecs[2]  = '{32'h004, 1'b0};
        vecs[3]  = '{32'h00C, 1'b0};
        vecs[4]  = '{32'h100, 1'b1};
        vecs[5]  = '{32'h10C, 1'b0};
        vecs[6]  = '{32'h000, 1'b1};
        vecs[7]  = '{32'h010, 1'b1};
        vecs[8]  = '{32'h01C, 1'b0};
        vecs[9]  = '{32'h03C, 1'b1};
        vecs[10] = '{32'h110, 1'b1};
        vecs[11] = '{32'h014, 1'b1};

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].addr, vecs[i].miss);
            wait_pulse($sformatf("vec%0d", i), vecs[i].miss);
        end

        // Flush mid-refill: line 0x0 still installs, only the new pc 0x40 is answered.
        do_reset();
        push_line(32'h000);
        push_line(32'h040);
        exp_q.push_back({32'h040, mem_word(32'h040)});
        pc = 32'h000;
        start_fetch = 1'b1;
        wait_addr("flush_beat2", 32'h004);
        @(posedge clk);
        #1;
        rob_clear_up = 1'b1;
        pc = 32'h040;
        tick();
        rob_clear_up = 1'b0;
        wait_pulse("flush_new_pc", 1'b1);
        issue(32'h000, 1'b0);
        wait_pulse("flush_line_kept", 1'b0);

        // Flush held in IDLE on a hit: no response until it drops.
        issue(32'h008, 1'b0);
        rob_clear_up = 1'b1;
        repeat (3) tick();
        rob_clear_up = 1'b0;
        wait_pulse("idle_flush", 1'b0);

        // Freeze for 3 cycles mid-refill.
        issue(32'h200, 1'b1);
        wait_addr("freeze_start", 32'h204);
        @(posedge clk);
        #1;
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("freeze_mem_req", {31'b0, mem_req}, 32'd1);
            check("freeze_state", {30'b0, dbg_state}, {30'b0, ST_REFILL});
            if (beat_q.size() > 0) check("freeze_mem_addr", mem_addr, beat_q[0]);
        end
        @(posedge clk);
        #1;
        rdy_in = 1'b1;
        wait_pulse("freeze_resume", 1'b1);
        issue(32'h208, 1'b0);
        wait_pulse("freeze_line_hit", 1'b0);

        // Reset mid-refill abandons the line.
        issue(32'h300, 1'b1);
        wait_addr("rst_mid", 32'h304);
        @(posedge clk);
        #1;
        do_reset();
        issue(32'h304, 1'b1);
        wait_pulse("after_rst_mid", 1'b1);

        repeat (4) tick();
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("beat_q_drained", beat_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
